// File: rtl/button_debounce_pkg.sv
// Shared button timing constants and FSM state encoding, also used by the
// game FSMs for pulse timing.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // Defaults for a 50 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_LONG_CYCLES     = 50000000;
  localparam int DEF_REPEAT_CYCLES   = 12500000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Debounces one synchronized button level and turns it into a clean level
// plus one-cycle press, release, long-press and auto-repeat pulses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_V    = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] REPEAT_V  = HW'(REPEAT_CYCLES);
  localparam bit            REPEAT_EN = (REPEAT_CYCLES != 0);

  state_t        state, state_n;
  logic [DW-1:0] deb_cnt, deb_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          long_done, long_done_n;
  logic          level_n, press_n, release_n, long_n, repeat_n;

  logic [HW-1:0] hold_inc;
  logic [HW-1:0] hold_adv;
  logic          long_fire, repeat_fire;

  // One held cycle of the hold counter: fire long/repeat when the running
  // interval completes, otherwise count; it parks once repeat is disabled.
  always_comb begin
    hold_inc    = hold_cnt + HW'(1);
    hold_adv    = hold_cnt;
    long_fire   = 1'b0;
    repeat_fire = 1'b0;
    if (!long_done) begin
      if (hold_inc == LONG_V) begin
        long_fire = 1'b1;
        hold_adv  = '0;
      end else begin
        hold_adv  = hold_inc;
      end
    end else if (REPEAT_EN) begin
      if (hold_inc == REPEAT_V) begin
        repeat_fire = 1'b1;
        hold_adv    = '0;
      end else begin
        hold_adv    = hold_inc;
      end
    end
  end

  always_comb begin
    state_n     = state;
    deb_cnt_n   = deb_cnt;
    hold_cnt_n  = hold_cnt;
    long_done_n = long_done;
    level_n     = btn_level;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
    repeat_n    = 1'b0;
    unique case (state)
      RELEASED: begin
        if (btn_in) begin
          state_n   = PRESS_CHK;
          deb_cnt_n = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_in) begin
          state_n = RELEASED;
        end else if (deb_cnt == DEB_LAST) begin
          state_n     = PRESSED;
          level_n     = 1'b1;
          press_n     = 1'b1;
          hold_cnt_n  = '0;
          long_done_n = 1'b0;
        end else begin
          deb_cnt_n = deb_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!btn_in) begin
          state_n   = RELEASE_CHK;
          deb_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_adv;
          long_n     = long_fire;
          repeat_n   = repeat_fire;
          if (long_fire) long_done_n = 1'b1;
        end
      end
      RELEASE_CHK: begin
        // Returning to PRESSED counts as a held cycle but never pulses; an
        // interval that would complete here completes on the next edge.
        if (btn_in) begin
          state_n = PRESSED;
          if (!long_fire && !repeat_fire) hold_cnt_n = hold_adv;
        end else if (deb_cnt == DEB_LAST) begin
          state_n   = RELEASED;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          deb_cnt_n = deb_cnt + DW'(1);
        end
      end
      default: state_n = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      deb_cnt       <= deb_cnt_n;
      hold_cnt      <= hold_cnt_n;
      long_done     <= long_done_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: one instance with auto-repeat and one
// with repeat disabled, both driven by the same button stimulus.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  // Output vector order: {level, press, release, long, repeat}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] L  = 5'b10000;
  localparam logic [4:0] P  = 5'b11000;
  localparam logic [4:0] R  = 5'b00100;
  localparam logic [4:0] LG = 5'b10010;
  localparam logic [4:0] RP = 5'b10001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;

  logic lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic lvl_b, prs_b, rel_b, lng_b, rep_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       btn;
    logic       rst;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
    .long_pulse(lng_a), .repeat_pulse(rep_a)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
    .long_pulse(lng_b), .repeat_pulse(rep_b)
  );

  always #5 clk = ~clk;

  task automatic check_output(input logic [4:0] exp, input string name);
    logic [4:0] got_a, got_b, exp_b;
    got_a = {lvl_a, prs_a, rel_a, lng_a, rep_a};
    got_b = {lvl_b, prs_b, rel_b, lng_b, rep_b};
    exp_b = exp & 5'b11110;
    checks++;
    if (got_a !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (level,press,release,long,repeat)",
               name, got_a, exp);
    end
    checks++;
    if (got_b !== exp_b) begin
      errors++;
      $display("[TB] FAIL %s_norep: got %b, expected %b (level,press,release,long,repeat)",
               name, got_b, exp_b);
    end
  endtask

  task automatic apply_stimulus(input logic b, input logic r,
                                input logic [4:0] exp, input string name);
    @(negedge clk);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    #1;
    check_output(exp, name);
  endtask

  task automatic add_vec(input logic b, input logic r, input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{btn: b, rst: r, exp: e});
  endtask

  task automatic press_seq(input string name);
    for (int i = 1; i < DEB + 1; i++) apply_stimulus(1'b1, 1'b0, Z, {name, "_pchk"});
    apply_stimulus(1'b1, 1'b0, P, {name, "_press"});
  endtask

  task automatic release_seq(input string name);
    for (int i = 1; i < DEB + 1; i++) apply_stimulus(1'b0, 1'b0, L, {name, "_rchk"});
    apply_stimulus(1'b0, 1'b0, R, {name, "_release"});
  endtask

  // k counts held edges after the press edge, long_at is the edge the
  // long pulse is due on; repeats follow every REP edges.
  task automatic hold_run(input int k_first, input int k_last, input int long_at,
                          input string name);
    logic [4:0] e;
    for (int k = k_first; k <= k_last; k++) begin
      if (k == long_at) e = LG;
      else if (k > long_at && ((k - long_at) % REP) == 0) e = RP;
      else e = L;
      apply_stimulus(1'b1, 1'b0, e, $sformatf("%s_k%0d", name, k));
    end
  endtask

  initial begin
    add_vec(1'b0, 1'b1, Z, 2);
    add_vec(1'b0, 1'b0, Z, 2);
    add_vec(1'b1, 1'b0, Z, 4);
    add_vec(1'b1, 1'b0, P, 1);
    add_vec(1'b1, 1'b0, L, 2);
    add_vec(1'b0, 1'b0, L, 4);
    add_vec(1'b0, 1'b0, R, 1);
    add_vec(1'b0, 1'b0, Z, 2);
    add_vec(1'b1, 1'b0, Z, 3);
    add_vec(1'b0, 1'b0, Z, 1);
    add_vec(1'b1, 1'b0, Z, 3);
    add_vec(1'b0, 1'b0, Z, 2);
    add_vec(1'b1, 1'b0, Z, 4);
    add_vec(1'b1, 1'b0, P, 1);
    add_vec(1'b1, 1'b0, L, 1);
    add_vec(1'b0, 1'b0, L, 4);
    add_vec(1'b0, 1'b0, R, 1);
    add_vec(1'b0, 1'b0, Z, 1);

    foreach (vecs[i])
      apply_stimulus(vecs[i].btn, vecs[i].rst, vecs[i].exp, $sformatf("vec%0d", i));

    $display("[TB] long hold with repeat");
    press_seq("long");
    hold_run(1, 60, LONG, "long");
    release_seq("long");
    apply_stimulus(1'b0, 1'b0, Z, "long_idle");

    $display("[TB] release glitch");
    press_seq("glitch");
    hold_run(1, 10, LONG + 2, "glitch");
    apply_stimulus(1'b0, 1'b0, L, "glitch_low1");
    apply_stimulus(1'b0, 1'b0, L, "glitch_low2");
    hold_run(13, 31, LONG + 2, "glitch");
    release_seq("glitch");

    $display("[TB] clean release before long");
    press_seq("short");
    hold_run(1, 10, LONG, "short");
    release_seq("short");
    for (int i = 0; i < 25; i++) apply_stimulus(1'b0, 1'b0, Z, "short_idle");

    $display("[TB] reset mid-press");
    press_seq("rstmid");
    hold_run(1, 14, LONG, "rstmid");
    apply_stimulus(1'b1, 1'b1, Z, "rstmid_reset");
    press_seq("rstmid_new");
    hold_run(1, 22, LONG, "rstmid_new");
    release_seq("rstmid_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
